seq_packet_serializer: RTL

Downstream of the compressor core's sequence-packet output. It accepts one packet of up to SEQ_PACKET_SIZE sequence lanes per handshake and emits the strobed lanes one per cycle, in ascending lane order, on a single-sequence valid/ready stream. The entropy-coding stage consumes that stream. The block absorbs sparse packets and applies backpressure only while a packet is still draining.

---
 rtl/seq_packet_serializer_pkg.sv | 28 ++
 rtl/seq_packet_serializer_priority_onehot_select.sv | 33 +++
 rtl/seq_packet_serializer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/seq_packet_serializer_pkg.sv
// Shared widths, state encoding and helpers for the sequence-packet serializer.
// The lane struct here is the default-width view of one sequence.
package seq_packet_serializer_pkg;

  localparam int SEQ_PACKET_SIZE = 4;
  localparam int SEQ_LL_BITS     = 16;
  localparam int SEQ_ML_BITS     = 16;
  localparam int SEQ_OFFSET_BITS = 20;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  typedef struct packed {
    logic [SEQ_LL_BITS-1:0]     ll;
    logic [SEQ_ML_BITS-1:0]     ml;
    logic [SEQ_OFFSET_BITS-1:0] offset;
    logic [SEQ_ML_BITS-1:0]     overlap;
    logic                       eoj;
    logic                       delim;
  } seq_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_packet_serializer_priority_onehot_select.sv
// Lowest-set-bit picker: returns the winning lane both one-hot (for clearing
// pending) and as a binary index (for the lane mux).
module priority_onehot_select
  import seq_packet_serializer_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] index
);

  // lower_any[k] is set when any request below lane k is active
  logic [N-1:0] lower_any;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    if (gi == 0) begin : g_first
      assign lower_any[gi] = 1'b0;
    end else begin : g_rest
      assign lower_any[gi] = lower_any[gi-1] | req[gi-1];
    end
    assign onehot[gi] = req[gi] & ~lower_any[gi];
  end

  always_comb begin
    index = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) index = index | IDX_W'(i);
    end
  end

endmodule

// File: rtl/seq_packet_serializer.sv
// Accepts one packet of strobed sequence lanes and emits the strobed lanes one
// per cycle in ascending lane order on a single-sequence valid/ready stream.
module seq_packet_serializer
  import seq_packet_serializer_pkg::*;
#(
  parameter int PACKET_SIZE = SEQ_PACKET_SIZE,
  parameter int LL_BITS     = SEQ_LL_BITS,
  parameter int ML_BITS     = SEQ_ML_BITS,
  parameter int OFFSET_BITS = SEQ_OFFSET_BITS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_seq_packet_valid,
  output logic                           i_seq_packet_ready,
  input  logic [PACKET_SIZE-1:0]         i_seq_packet_strb,
  input  logic [PACKET_SIZE*LL_BITS-1:0] i_seq_packet_ll,
  input  logic [PACKET_SIZE*ML_BITS-1:0] i_seq_packet_ml,
  input  logic [PACKET_SIZE*OFFSET_BITS-1:0] i_seq_packet_offset,
  input  logic [PACKET_SIZE*ML_BITS-1:0] i_seq_packet_overlap,
  input  logic [PACKET_SIZE-1:0]         i_seq_packet_eoj,
  input  logic [PACKET_SIZE-1:0]         i_seq_packet_delim,
  output logic                           o_seq_valid,
  input  logic                           o_seq_ready,
  output logic [LL_BITS-1:0]             o_seq_ll,
  output logic [ML_BITS-1:0]             o_seq_ml,
  output logic [OFFSET_BITS-1:0]         o_seq_offset,
  output logic [ML_BITS-1:0]             o_seq_overlap,
  output logic                           o_seq_eoj,
  output logic                           o_seq_delim,
  output logic [31:0]                    o_seq_count
);

  localparam int IDX_W = idx_width(PACKET_SIZE);

  // Parameter-width view of seq_t so overridden widths stay consistent.
  typedef struct packed {
    logic [LL_BITS-1:0]     ll;
    logic [ML_BITS-1:0]     ml;
    logic [OFFSET_BITS-1:0] offset;
    logic [ML_BITS-1:0]     overlap;
    logic                   eoj;
    logic                   delim;
  } lane_t;

  lane_t                  lane_in  [PACKET_SIZE];
  lane_t                  hold_reg [PACKET_SIZE];
  lane_t                  out_lane;
  logic [PACKET_SIZE-1:0] pending_reg, pending_next;
  logic [PACKET_SIZE-1:0] sel_onehot;
  logic [IDX_W-1:0]       sel_idx;
  logic [31:0]            count_reg, count_next;
  state_e                 state;
  logic                   in_hs, out_hs;

  for (genvar gi = 0; gi < PACKET_SIZE; gi++) begin : g_unpack
    assign lane_in[gi] = '{
      ll:      i_seq_packet_ll[gi*LL_BITS +: LL_BITS],
      ml:      i_seq_packet_ml[gi*ML_BITS +: ML_BITS],
      offset:  i_seq_packet_offset[gi*OFFSET_BITS +: OFFSET_BITS],
      overlap: i_seq_packet_overlap[gi*ML_BITS +: ML_BITS],
      eoj:     i_seq_packet_eoj[gi],
      delim:   i_seq_packet_delim[gi]
    };
  end

  priority_onehot_select #(
    .N     (PACKET_SIZE),
    .IDX_W (IDX_W)
  ) u_select (
    .req    (pending_reg),
    .onehot (sel_onehot),
    .index  (sel_idx)
  );

  assign state  = (pending_reg != '0) ? DRAIN : IDLE;
  assign in_hs  = i_seq_packet_valid && i_seq_packet_ready;
  assign out_hs = o_seq_valid && o_seq_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= '0;
      count_reg   <= '0;
    end else begin
      pending_reg <= pending_next;
      count_reg   <= count_next;
    end
  end

  // Payload storage needs no reset: outputs are masked while nothing is pending.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      for (int k = 0; k < PACKET_SIZE; k++) hold_reg[k] <= lane_in[k];
    end
  end

  // A load overrides the last-lane clear so the new packet is never corrupted.
  always_comb begin
    pending_next = pending_reg;
    count_next   = count_reg;
    if (out_hs) begin
      pending_next = pending_reg & ~sel_onehot;
      count_next   = count_reg + 32'd1;
    end
    if (in_hs) pending_next = i_seq_packet_strb;
  end

  always_comb begin
    o_seq_valid        = (state == DRAIN);
    i_seq_packet_ready = (state == IDLE) ||
                         (o_seq_ready && ((pending_reg & ~sel_onehot) == '0));
    out_lane           = '0;
    if (state == DRAIN) out_lane = hold_reg[sel_idx];
  end

  assign o_seq_ll      = out_lane.ll;
  assign o_seq_ml      = out_lane.ml;
  assign o_seq_offset  = out_lane.offset;
  assign o_seq_overlap = out_lane.overlap;
  assign o_seq_eoj     = out_lane.eoj;
  assign o_seq_delim   = out_lane.delim;
  assign o_seq_count   = count_reg;

endmodule
